// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// Optional leading-zero blanking on the result when BIN2BCD_BLANK_EN is defined.
module bin2bcd_seq #(
  parameter int BIN_W  = 64,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   bin_sr;
  logic [BCD_W-1:0]   work;
  logic [BCD_W-1:0]   work_adj;
  logic [BCD_W-1:0]   bcd_fmt;
  logic [CNT_W-1:0]   cnt;
  logic               sticky;
  logic               accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready & ~reset;

  always_comb begin
    work_adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] >= 4'd5)
        work_adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic seen_nz;

  // Blank zeros above the most significant nonzero digit; units digit always shown.
  always_comb begin
    bcd_fmt = work;
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (work[4*i +: 4] != 4'd0)
        seen_nz = 1'b1;
      if (!seen_nz)
        bcd_fmt[4*i +: 4] = 4'hF;
    end
  end
`else
  assign bcd_fmt = work;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST_CNT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_sr    <= '0;
      work      <= '0;
      sticky    <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bin_sr <= bin_in;
            work   <= '0;
            sticky <= 1'b0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          // Carry out of the top digit is a multiple of 10^DIGITS: drop it, remember it.
          {work, bin_sr} <= {work_adj[BCD_W-2:0], bin_sr, 1'b0};
          sticky         <= sticky | work_adj[BCD_W-1];
          cnt            <= cnt + 1'b1;
        end
        DONE: begin
          bcd_out   <= bcd_fmt;
          overflow  <= sticky;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq against an arithmetic mod-10^8 reference.
// Honours BIN2BCD_BLANK_EN in the expected values.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] bin_in;
  logic        out_valid;
  logic [31:0] bcd_out;
  logic        overflow;

  int checks = 0;
  int failures = 0;

`ifdef BIN2BCD_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  bin2bcd_seq #(.BIN_W(64), .DIGITS(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bin_in    (bin_in),
    .out_valid (out_valid),
    .bcd_out   (bcd_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_bcd(input logic [63:0] v);
    logic [63:0] m;
    int          d[8];
    logic [31:0] r;
    m = v % 64'd100000000;
    for (int i = 0; i < 8; i++) begin
      d[i] = int'(m % 64'd10);
      m    = m / 64'd10;
    end
    if (BLANK) begin
      for (int i = 7; i >= 1; i--) begin
        if (d[i] == 0) d[i] = 15;
        else break;
      end
    end
    r = '0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = d[i][3:0];
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [63:0] v);
    return v >= 64'd100000000;
  endfunction

  // Drives one conversion from idle and reports what came back; callers judge it.
  task automatic run_conv(input logic [63:0] v, output logic [31:0] bcd, output logic ovf,
                          output int lat, output bit busy_ok);
    logic [31:0] prev;
    lat     = -1;
    busy_ok = 1'b1;
    @(negedge clk);
    prev     = bcd_out;
    in_valid = 1'b1;
    bin_in   = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    bin_in   = {$urandom, $urandom};
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
      if (in_ready !== 1'b0 || bcd_out !== prev || overflow !== 1'b0 && prev === 32'h0 && n == 1)
        busy_ok = 1'b0;
    end
    bcd = bcd_out;
    ovf = overflow;
  endtask

  task automatic test_reset();
    int strobes;
    reset    = 1'b1;
    in_valid = 1'b1;
    bin_in   = 64'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || bcd_out !== 32'h0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b bcd_out=%h overflow=%b, required 1 0 00000000 0",
               in_ready, out_valid, bcd_out, overflow);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    strobes  = 0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      failures++;
      $display("FAIL no_accept_in_reset: out_valid strobes=%0d, required 0", strobes);
    end
  endtask

  task automatic test_zero();
    logic [31:0] bcd; logic ovf; int lat; bit ok;
    logic [31:0] exp;
    exp = BLANK ? 32'hFFFFFFF0 : 32'h00000000;
    run_conv(64'd0, bcd, ovf, lat, ok);
    checks++;
    if (bcd !== exp || ovf !== 1'b0 || lat != 65) begin
      failures++;
      $display("FAIL zero: bcd=%h ovf=%b lat=%0d, required %h 0 65", bcd, ovf, lat, exp);
    end
  endtask

  task automatic test_timing();
    logic [31:0] bcd; logic ovf; int lat; bit ok;
    run_conv(64'd12345678, bcd, ovf, lat, ok);
    checks++;
    if (lat != 65) begin
      failures++;
      $display("FAIL latency: out_valid after edge %0d, required 65", lat);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL busy_outputs: in_ready low / bcd_out stable while busy = %b, required 1", ok);
    end
    checks++;
    if (bcd !== 32'h12345678 || ovf !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL value_12345678: bcd=%h ovf=%b in_ready=%b, required 12345678 0 1", bcd, ovf, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || bcd_out !== 32'h12345678) begin
      failures++;
      $display("FAIL strobe_width: out_valid=%b bcd_out=%h next cycle, required 0 12345678", out_valid, bcd_out);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] bcd; logic ovf; int lat; bit ok;
    logic [31:0] exp;
    run_conv(64'd99999999, bcd, ovf, lat, ok);
    checks++;
    if (bcd !== 32'h99999999 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL bound_99999999: bcd=%h ovf=%b, required 99999999 0", bcd, ovf);
    end
    exp = BLANK ? 32'hFFFFFFF0 : 32'h00000000;
    run_conv(64'd100000000, bcd, ovf, lat, ok);
    checks++;
    if (bcd !== exp || ovf !== 1'b1) begin
      failures++;
      $display("FAIL bound_100000000: bcd=%h ovf=%b, required %h 1", bcd, ovf, exp);
    end
    exp = BLANK ? 32'hF9551615 : 32'h09551615;
    run_conv(64'hFFFF_FFFF_FFFF_FFFF, bcd, ovf, lat, ok);
    checks++;
    if (bcd !== exp || ovf !== 1'b1) begin
      failures++;
      $display("FAIL max_value: bcd=%h ovf=%b, required %h 1", bcd, ovf, exp);
    end
  endtask

  task automatic test_random();
    logic [31:0] bcd; logic ovf; int lat; bit ok;
    logic [63:0] v;
    for (int i = 0; i < 18; i++) begin
      case (i % 3)
        0:       v = 64'($urandom_range(0, 99999));
        1:       v = 64'd99999990 + 64'($urandom_range(0, 20));
        default: v = {$urandom, $urandom};
      endcase
      run_conv(v, bcd, ovf, lat, ok);
      checks++;
      if (bcd !== ref_bcd(v) || ovf !== ref_ovf(v) || lat != 65) begin
        failures++;
        $display("FAIL random[%0d] v=%0d: bcd=%h ovf=%b lat=%0d, required %h %b 65",
                 i, v, bcd, ovf, lat, ref_bcd(v), ref_ovf(v));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] bcd; logic ovf; int lat; bit ok;
    int strobes;
    logic [31:0] exp;
    run_conv(64'd99, bcd, ovf, lat, ok);
    strobes = 0;
    @(negedge clk);
    in_valid = 1'b1;
    bin_in   = 64'd5555;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (19) begin
      @(posedge clk);
      #1;
      if (out_valid) strobes++;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || bcd_out !== 32'h0 || overflow !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid: out_valid=%b bcd=%h ovf=%b in_ready=%b, required 0 00000000 0 1",
               out_valid, bcd_out, overflow, in_ready);
    end
    reset = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid || bcd_out !== 32'h0) strobes++;
    end
    checks++;
    if (strobes != 0) begin
      failures++;
      $display("FAIL reset_abort: stray strobes/changes=%0d, required 0", strobes);
    end
    exp = BLANK ? 32'hFFFFFF42 : 32'h00000042;
    run_conv(64'd42, bcd, ovf, lat, ok);
    checks++;
    if (bcd !== exp || ovf !== 1'b0 || lat != 65) begin
      failures++;
      $display("FAIL after_reset_42: bcd=%h ovf=%b lat=%0d, required %h 0 65", bcd, ovf, lat, exp);
    end
  endtask

  task automatic test_back_to_back();
    int          cnt;
    int          edge_at[2];
    logic [31:0] val[2];
    logic [31:0] e7, e8;
    e7  = BLANK ? 32'hFFFFFFF7 : 32'h00000007;
    e8  = BLANK ? 32'hFFFFFFF8 : 32'h00000008;
    cnt = 0;
    edge_at[0] = -1; edge_at[1] = -1;
    val[0] = '0; val[1] = '0;
    @(negedge clk);
    in_valid = 1'b1;
    bin_in   = 64'd7;
    @(posedge clk);
    #1;
    bin_in = 64'd8;
    for (int n = 1; n <= 140; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        if (cnt < 2) begin
          edge_at[cnt] = n;
          val[cnt]     = bcd_out;
        end
        cnt++;
      end
      if (n == 131) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (cnt != 2 || edge_at[0] != 65 || edge_at[1] != 131) begin
      failures++;
      $display("FAIL b2b_timing: strobes=%0d at edges %0d,%0d, required 2 at 65,131",
               cnt, edge_at[0], edge_at[1]);
    end
    checks++;
    if (val[0] !== e7 || val[1] !== e8) begin
      failures++;
      $display("FAIL b2b_values: %h,%h, required %h,%h", val[0], val[1], e7, e8);
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    bin_in   = '0;
    test_reset();
    test_zero();
    test_timing();
    test_boundary();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock. Sits between the 64-bit seconds counter and the eight-digit LED scanner, replacing the wide combinational divide/modulo chain. Produces the low `DIGITS` decimal digits of the input value (value mod 10^DIGITS) plus an overflow flag. A valid/ready handshake on the input and a one-cycle `out_valid` strobe on the output frame each conversion.

## Interface
- `BIN_W`, 64: width of the binary input; also the number of shift cycles per conversion.
- `DIGITS`, 8: number of BCD digits produced (4 bits each).

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  `bin_in` holds a value to convert.
- `in_ready`  out  1  block is idle and accepts a value (`state==IDLE`).
- `bin_in`  in  BIN_W  unsigned binary value, sampled on the accept edge only.
- `out_valid`  out  1  one-cycle strobe: `bcd_out`/`overflow` just updated.
- `bcd_out`  out  4*DIGITS  result digits, digit 0 (units) in bits [3:0]; held until the next completion.
- `overflow`  out  1  `bin_in` was ≥ 10^DIGITS; held with `bcd_out`.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: `in_ready`=1. An accept edge (`in_valid & in_ready`) does the following:
  - load the binary shift register with `bin_in`;
  - clear the BCD work register and the sticky overflow bit;
  - clear the bit counter (width `$clog2(BIN_W+1)`);
  - move to SHIFT.
- SHIFT, on each edge:
  - add 3 to every work digit ≥ 5;
  - shift {BCD work, binary} left by 1; the binary MSB enters BCD bit 0;
  - OR the bit shifted out of the top BCD digit into sticky overflow;
  - increment the counter.
  - After the BIN_W-th shift edge, move to DONE.
- DONE (one cycle), on its edge:
  - register `bcd_out` ← work register (through the blanking stage if compiled in);
  - register `overflow` ← sticky bit;
  - `out_valid` ← 1;
  - move to IDLE.
- `out_valid` is registered and deasserts on the following edge.
- Truncating the top carry yields exactly value mod 10^DIGITS. Sticky overflow equals (value ≥ 10^DIGITS).
- `in_valid` while not in IDLE is ignored. No input is queued, and `bin_in` changes mid-conversion have no effect.
- Reset values:
  - state IDLE, so `in_ready`=1;
  - `out_valid`=0, `bcd_out`=0, `overflow`=0;
  - work registers 0.
- While `reset` is high, no accept occurs, even though `in_ready` reads 1.
- Reset mid-conversion aborts the conversion: no `out_valid` is produced, and the previous `bcd_out` is cleared to 0.

## Timing
- Accept at edge 0. Shift edges are 1..BIN_W. The DONE edge is BIN_W+1. `out_valid` is high in the cycle after edge BIN_W+1.
- Latency is BIN_W+1 edges (65 for the defaults).
- `in_ready` rises in the same cycle `out_valid` is high. The earliest next accept is edge BIN_W+2, so sustained throughput is one conversion per BIN_W+2 cycles (66 for the defaults).
- `bcd_out` and `overflow` change only on the DONE edge (or on reset). They are stable in every other cycle.
- All outputs are registered except `in_ready`, which is decoded from the state register.

## Configuration
- Macro: `BIN2BCD_BLANK_EN`.
- When defined: leading-zero blanking is applied on the DONE edge.
  - Each zero digit above the most significant nonzero digit is replaced with 4'hF, the display blank code.
  - Digit 0 is never blanked, so value 0 shows "0".
  - Blanking is based on the truncated digits. If overflow=1 and the top digits are zero, they are blanked.
- When undefined: digits are output unmodified, with leading zeros shown as 0.

## Test plan
- `bin_in`=0 → `bcd_out`=32'h00000000 and `overflow`=0. With `BIN2BCD_BLANK_EN`, `bcd_out`=32'hFFFFFFF0.
- `bin_in`=12345678 accepted at edge 0 → `out_valid` high exactly one cycle after edge 65; `bcd_out`=32'h12345678; `in_ready`=0 from edge 1 through edge 65.
- Boundary:
  - 99999999 → 32'h99999999 with `overflow`=0;
  - 100000000 → 32'h00000000 with `overflow`=1.
- `bin_in`=64'hFFFF_FFFF_FFFF_FFFF (18446744073709551615) → `bcd_out`=32'h09551615 and `overflow`=1. With blanking, the result is 32'hF9551615.
- Reset during conversion:
  - accept 5555, assert `reset` on edge 20 → all outputs 0, no `out_valid`, `in_ready`=1;
  - then accept 42 → 32'h00000042 after 65 edges.
- `in_valid` held high with value 7, changed to 8 right after the first accept:
  - exactly two `out_valid` strobes, 66 cycles apart;
  - the first gives 32'h00000007, the second 32'h00000008;
  - no accept occurs while busy.
